// File: rtl/led_scan_pkg.sv
// Shared types and constants for the 8x8 LED matrix scan driver.
package led_scan_pkg;

  localparam int unsigned ROWS = 8;
  localparam int unsigned COLS = 8;

  typedef enum logic [0:0] {
    S_IDLE,
    S_SCAN
  } scan_state_t;

  typedef logic [ROWS-1:0][COLS-1:0] frame_t;

endpackage

// File: rtl/blink_timer.sv
// Counts frame wraps and toggles the cursor blink phase every BLINK_FRAMES frames.
module blink_timer #(
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic frame_wrap,
  output logic phase
);

  localparam int unsigned CntWidth = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(BLINK_FRAMES - 1);

  logic [CntWidth-1:0] count_q, count_d;
  logic                phase_q, phase_d;

  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (clear) begin
      count_d = '0;
      phase_d = 1'b0;
    end else if (frame_wrap) begin
      if (count_q == CntLast) begin
        count_d = '0;
        phase_d = ~phase_q;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      count_q <= '0;
      phase_q <= 1'b0;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/led_scan_driver.sv
// Row-multiplexed 8x8 LED driver: double-buffered frame, per-row dwell with leading
// blanking, and a blinking inverted cursor row. All outputs are registered.
module led_scan_driver
  import led_scan_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 1024,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Enable,
  input  logic [7:0][7:0] lights,
  input  logic [2:0]      cursor,
  input  logic            cursor_en,
  output logic [7:0]      row_sel,
  output logic [7:0]      col_data,
  output logic            frame_done
);

  localparam int unsigned DwellWidth = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DwellWidth-1:0] DwellLast = DwellWidth'(DWELL_CYCLES - 1);

  scan_state_t           state_q, state_d;
  logic [2:0]            row_q, row_d;
  logic [DwellWidth-1:0] dwell_q, dwell_d;
  frame_t                shadow_q, shadow_d;
  logic [2:0]            cursor_q, cursor_d;
  logic                  cursor_en_q, cursor_en_d;
  logic [7:0]            row_sel_q, row_sel_d;
  logic [7:0]            col_data_q, col_data_d;
  logic                  frame_done_q, frame_done_d;

  logic last_dwell;
  logic frame_wrap;
  logic capture;
  logic in_blank;
  logic blink_phase;

  // A zero-length blanking window must not produce an always-false unsigned compare.
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign in_blank = 1'b0;
  end else begin : g_blank
    assign in_blank = 32'(dwell_q) < BLANK_CYCLES;
  end

  always_comb begin
    last_dwell = (dwell_q == DwellLast);
    frame_wrap = Enable && (state_q == S_SCAN) && last_dwell && (row_q == 3'd7);
    // Idle exit and frame wrap are the only points where the frame is latched.
    capture    = Enable && ((state_q == S_IDLE) || frame_wrap);
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    dwell_d = dwell_q;
    if (!Enable) begin
      state_d = S_IDLE;
      row_d   = '0;
      dwell_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_SCAN;
          row_d   = '0;
          dwell_d = '0;
        end
        S_SCAN: begin
          if (last_dwell) begin
            dwell_d = '0;
            row_d   = row_q + 3'd1;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    shadow_d    = shadow_q;
    cursor_d    = cursor_q;
    cursor_en_d = cursor_en_q;
    if (capture) begin
      shadow_d    = lights;
      cursor_d    = cursor;
      cursor_en_d = cursor_en;
    end
  end

  // Outputs are a registered decode of the current scan position.
  always_comb begin
    row_sel_d    = '0;
    col_data_d   = '0;
    frame_done_d = 1'b0;
    if (Enable && (state_q == S_SCAN)) begin
      if (!in_blank) begin
        row_sel_d  = 8'b1 << row_q;
        col_data_d = shadow_q[row_q];
        if (cursor_en_q && (cursor_q == row_q) && blink_phase) begin
          col_data_d = ~shadow_q[row_q];
        end
      end
      frame_done_d = last_dwell && (row_q == 3'd7);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      dwell_q      <= '0;
      shadow_q     <= '0;
      cursor_q     <= '0;
      cursor_en_q  <= 1'b0;
      row_sel_q    <= '0;
      col_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      dwell_q      <= dwell_d;
      shadow_q     <= shadow_d;
      cursor_q     <= cursor_d;
      cursor_en_q  <= cursor_en_d;
      row_sel_q    <= row_sel_d;
      col_data_q   <= col_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink_timer (
    .Clock     (Clock),
    .Reset     (Reset),
    .clear     (!Enable),
    .frame_wrap(frame_wrap),
    .phase     (blink_phase)
  );

  assign row_sel    = row_sel_q;
  assign col_data   = col_data_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/led_scan_driver.md
# led_scan_driver

Row-multiplexed driver for the 8×8 LED matrix. It sits directly downstream of the user-input stage, which produces the `lights` frame and the current cursor row. The driver double-buffers the frame, then scans it one row at a time with a programmable dwell and an anti-ghosting blanking interval. It also overlays a blinking inverted cursor row so the user can see which row the up/down controls select.

## Interface
Parameters:
- `DWELL_CYCLES`, default 1024: clock cycles per row, blanking included; must be ≥ `BLANK_CYCLES`+1.
- `BLANK_CYCLES`, default 2: cycles at the start of each row with all outputs dark; ≥ 0.
- `BLINK_FRAMES`, default 32: frames per cursor blink half-period; ≥ 1.

Ports:
- `Clock` in 1: sole clock; all logic on posedge.
- `Reset` in 1: synchronous, active-low; `Reset`==0 at a posedge resets the block.
- `Enable` in 1: scan enable; low forces idle.
- `lights` in [7:0][7:0]: frame from upstream; `lights[r]` is row r, bit c is column c.
- `cursor` in 3: row index currently selected upstream.
- `cursor_en` in 1: show the cursor overlay.
- `row_sel` out 8: one-hot active-high row drive.
- `col_data` out 8: column data for the driven row.
- `frame_done` out 1: one-cycle pulse on the last cycle of each frame.

## Operation
- All outputs come from registers; there is no combinational path from inputs to outputs.
- Reset values: `row_sel`=0, `col_data`=0, `frame_done`=0, shadow frame=0, row=0, dwell=0, blink count=0, blink phase=0, state `S_IDLE`.
- **`S_IDLE`:** outputs 0 and counters 0.
  - `Enable`=1 at a posedge moves to `S_SCAN` at row 0, dwell 0.
  - At that same edge the block captures `lights`, `cursor` and `cursor_en` into shadow registers.
- **`S_SCAN`:** dwell counts 0..`DWELL_CYCLES`-1. At `DWELL_CYCLES`-1 it wraps to 0 and the row increments.
  - Row 7 wraps to row 0, which starts a new frame.
  - The shadow capture repeats at every frame-start edge. Changes to `lights` mid-frame never alter the frame being displayed.
- Output decode in `S_SCAN`:
  - While dwell < `BLANK_CYCLES`: `row_sel`=0, `col_data`=0.
  - Otherwise: `row_sel`=1<<row and `col_data`=shadow[row].
  - If shadow `cursor_en`=1, row equals shadow cursor, and blink phase=1, then `col_data`=~shadow[row].
- `frame_done`=1 exactly while row=7 and dwell=`DWELL_CYCLES`-1. This includes the case `DWELL_CYCLES`=1.
- Blink: the blink count increments at each frame wrap.
  - When it reaches `BLINK_FRAMES`-1 and wraps, the blink phase toggles.
  - The first `BLINK_FRAMES` frames after reset or idle exit show phase 0, i.e. normal, not inverted.
- **`Enable`=0 in any state:** at the next edge the block returns to `S_IDLE`. Outputs and row/dwell are 0 and blink count and phase clear. The shadow frame is retained until the next capture.
- **`Reset`=0 mid-scan:** restores all reset values at that edge. `Reset` has priority over `Enable`.
- Counter widths:
  - dwell: `$clog2(DWELL_CYCLES)`, minimum 1 bit.
  - blink: `$clog2(BLINK_FRAMES)`, minimum 1 bit.
  - row: 3 bits, wrapping naturally.

## Timing
- Frame length is exactly 8×`DWELL_CYCLES` cycles. There are no gap cycles between rows or frames.
- Latency from `Enable` rising (sampled at edge N) to row 0 drive:
  - at edge N+1 `BLANK_CYCLES` is 0, so `row_sel`=0x01 from that edge;
  - otherwise `row_sel`=0x01 from edge N+1+`BLANK_CYCLES`.
- `lights` is sampled only on frame-start edges.
- Simultaneous `Enable` falling and frame wrap: idle wins and no capture occurs.

## Structure
- Package `led_scan_pkg`:
  - constants `ROWS`=8, `COLS`=8;
  - state enum `scan_state_t` {`S_IDLE`, `S_SCAN`};
  - typedef `frame_t` = logic [7:0][7:0].
- One sub-module, `blink_timer`: frame-wrap pulse in, blink phase out, with `Clock`/`Reset`/clear ports.

## Test plan
Use `DWELL_CYCLES`=4, `BLANK_CYCLES`=1, `BLINK_FRAMES`=2.
- **Reset:** `Reset`=0 for 2 cycles with `Enable`=1 → `row_sel`=0, `col_data`=0, `frame_done`=0 throughout.
- **Basic scan:** `lights[k]`=8'h01<<k, `cursor_en`=0, `Enable`=1 → each row gives 1 cycle of 0/0, then 3 cycles of `row_sel`=`col_data`=1<<k. `frame_done` pulses once every 32 cycles.
- **No tearing:** change `lights[6]` from 8'h40 to 8'hFF while row 3 is driving → the current frame still shows 8'h40 on row 6, and the next frame shows 8'hFF.
- **Cursor blink:** `cursor`=5, `cursor_en`=1, `lights[5]`=8'hA5 → row 5 shows A5 in frames 0–1, 5A in frames 2–3, and A5 in frames 4–5. Other rows are unchanged.
- **Enable drop:** deassert during row 4 → outputs are 0 at the next edge. Reasserting restarts at row 0 with a blank cycle, a fresh capture, and blink phase 0.
- **Reset mid-scan:** `Reset`=0 during row 6, phase 1 → all outputs 0 at the next edge. After release the block restarts from row 0 with phase 0.
